imem_responder: RTL

Instruction-memory responder on the memory side of the instruction-fetch path. It watches the word address driven by the instruction cache. It models a fixed multi-cycle access latency and returns the addressed word with a one-cycle-wide-or-longer `mem_valid` qualifier. Alignment and range errors are flagged, and a write port lets the bench or boot logic preload program contents.

---
 rtl/imem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency word reads for the instruction cache,
// with misaligned/out-of-range fault reporting and a preload write port.
module imem_responder #(
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 4,
   parameter logic [31:0] FAULT_WORD  = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_dataOut,
   output logic        mem_valid,
   output logic        access_fault,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data
);

   // state  | meaning
   // S_IDLE | just out of reset; next edge captures mem_addr
   // S_WAIT | counting down the access latency for cur_addr_q
   // S_RESP | response presented; held until mem_addr changes

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_START = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state_q;
   logic [31:0]   cur_addr_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   data_q;
   logic          valid_q;
   logic          fault_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic        addr_match;
   logic        fault_c;
   logic        load_in_range;
   logic [31:0] rd_word;
   logic        unused_load_lsbs;

   assign addr_match    = (mem_addr == cur_addr_q);
   assign fault_c       = (cur_addr_q[1:0] != 2'b00) ||
                          ({2'b00, cur_addr_q[31:2]} >= 32'(DEPTH_WORDS));
   assign load_in_range = ({2'b00, load_addr[31:2]} < 32'(DEPTH_WORDS));
   assign rd_word       = mem_q[cur_addr_q[AW+1:2]];
   assign unused_load_lsbs = ^load_addr[1:0];

   // Preload port; a write on the edge that enters S_RESP is not seen by that read.
   always_ff @(posedge clock) begin
      if (load_en && load_in_range) begin
         mem_q[load_addr[AW+1:2]] <= load_data;
      end
   end

   // Capture always passes through S_WAIT, so LATENCY=1 still gives one cycle to valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cur_addr_q <= 32'h0;
         cnt_q      <= '0;
         data_q     <= 32'h0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cur_addr_q <= mem_addr;
               cnt_q      <= CNT_START;
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               if (!addr_match) begin
                  cur_addr_q <= mem_addr;
                  cnt_q      <= CNT_START;
               end else if (cnt_q == '0) begin
                  state_q <= S_RESP;
                  valid_q <= 1'b1;
                  fault_q <= fault_c;
                  data_q  <= fault_c ? FAULT_WORD : rd_word;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_RESP: begin
               if (!addr_match) begin
                  cur_addr_q <= mem_addr;
                  cnt_q      <= CNT_START;
                  state_q    <= S_WAIT;
                  valid_q    <= 1'b0;
                  fault_q    <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_dataOut  = data_q;
   assign mem_valid    = valid_q;
   assign access_fault = fault_q;

endmodule
